// File: rtl/delta_countdown.sv
// Loadable down-counter: steps by DELTA every FACTOR+1 enabled cycles to FLOOR, one-cycle done pulse.
// Latency ceil((V-FLOOR)/DELTA)*(FACTOR+1) cycles; loads are accepted in IDLE only (load_ready_o).
module delta_countdown #(
    parameter int SIZE   = 8,
    parameter int DELTA  = 1,
    parameter int FACTOR = 1,
    parameter int FLOOR  = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ena_i,
    input  logic            load_valid_i,
    output logic            load_ready_o,
    input  logic [SIZE-1:0] load_value_i,
    input  logic            auto_reload_i,
    input  logic            abort_i,
    output logic [SIZE-1:0] count_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int               SW       = (FACTOR > 0) ? $clog2(FACTOR + 1) : 1;
    localparam logic [SW-1:0]    FACTOR_W = SW'(FACTOR);
    localparam logic [SIZE-1:0]  FLOOR_W  = SIZE'(FLOOR);
    localparam logic [SIZE-1:0]  DELTA_W  = SIZE'(DELTA);
    // One extra bit so FLOOR+DELTA cannot wrap.
    localparam logic [SIZE:0]    TERM_W   = (SIZE + 1)'(FLOOR + DELTA);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t          r_state,  w_state_nxt;
    logic [SIZE-1:0] r_count,  w_count_nxt;
    logic [SIZE-1:0] r_reload, w_reload_nxt;
    logic [SW-1:0]   r_scale,  w_scale_nxt;
    logic            r_done,   w_done_nxt;
    logic            w_terminal;

    assign w_terminal = ({1'b0, r_count} <= TERM_W);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_scale  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_scale  <= w_scale_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_scale_nxt  = r_scale;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_valid_i) begin
                    w_count_nxt  = load_value_i;
                    w_reload_nxt = load_value_i;
                    w_scale_nxt  = '0;
                    if (load_value_i > FLOOR_W) w_state_nxt = ST_RUN;
                    else                        w_done_nxt  = 1'b1;
                end
            end
            ST_RUN: begin
                // Abort wins over a step landing in the same cycle.
                if (abort_i) begin
                    w_state_nxt = ST_IDLE;
                    w_scale_nxt = '0;
                end else if (ena_i) begin
                    if (r_scale != FACTOR_W) begin
                        w_scale_nxt = r_scale + 1'b1;
                    end else begin
                        w_scale_nxt = '0;
                        if (!w_terminal) begin
                            w_count_nxt = r_count - DELTA_W;
                        end else begin
                            w_done_nxt = 1'b1;
                            if (auto_reload_i) begin
                                w_count_nxt = r_reload;
                            end else begin
                                w_count_nxt = FLOOR_W;
                                w_state_nxt = ST_IDLE;
                            end
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign count_o      = r_count;
    assign done_o       = r_done;
    assign busy_o       = (r_state == ST_RUN);
    assign load_ready_o = (r_state == ST_IDLE);

endmodule

// File: tb/tb_delta_countdown.sv
// Bench for delta_countdown: three parameterisations share one input set; each vector checks one of them.
module tb_delta_countdown;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ena, lv, ar, ab;
    logic [7:0] val;
    logic [7:0] cnt0, cnt1, cnt2;
    logic       rdy0, rdy1, rdy2, busy0, busy1, busy2, done0, done1, done2;

    delta_countdown u_d0 (
        .clk_i(clk), .rst_i(rst), .ena_i(ena), .load_valid_i(lv), .load_ready_o(rdy0),
        .load_value_i(val), .auto_reload_i(ar), .abort_i(ab), .count_o(cnt0),
        .busy_o(busy0), .done_o(done0));

    delta_countdown #(.DELTA(3), .FLOOR(2), .FACTOR(0)) u_d1 (
        .clk_i(clk), .rst_i(rst), .ena_i(ena), .load_valid_i(lv), .load_ready_o(rdy1),
        .load_value_i(val), .auto_reload_i(ar), .abort_i(ab), .count_o(cnt1),
        .busy_o(busy1), .done_o(done1));

    delta_countdown #(.FACTOR(0)) u_d2 (
        .clk_i(clk), .rst_i(rst), .ena_i(ena), .load_valid_i(lv), .load_ready_o(rdy2),
        .load_value_i(val), .auto_reload_i(ar), .abort_i(ab), .count_o(cnt2),
        .busy_o(busy2), .done_o(done2));

    typedef struct {
        int         sel;
        logic       rst, ena, lv;
        logic [7:0] val;
        logic       ar, ab;
        logic [7:0] cnt;
        logic       busy, done;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void add(input int sel, input logic r, input logic e, input logic l,
                                input logic [7:0] v, input logic a, input logic b,
                                input logic [7:0] c, input logic bz, input logic d);
        vec_t t;
        t.sel = sel; t.rst = r; t.ena = e; t.lv = l; t.val = v; t.ar = a; t.ab = b;
        t.cnt = c; t.busy = bz; t.done = d;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %0d, want %0d", name, idx, act, exp);
        end
    endtask

    task automatic sample(input int sel, output logic [7:0] c, output logic r, output logic b, output logic d);
        case (sel)
            0:       begin c = cnt0; r = rdy0; b = busy0; d = done0; end
            1:       begin c = cnt1; r = rdy1; b = busy1; d = done1; end
            default: begin c = cnt2; r = rdy2; b = busy2; d = done2; end
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; lv = 1'b0; ab = 1'b0; ar = 1'b0; ena = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Load V with ena held high and count cycles to done, bounded.
    task automatic latency(input int sel, input int v, input int delta, input int floor, input int factor);
        int         n;
        int         exp_n;
        logic [7:0] c;
        logic       r, b, d;
        exp_n = ((v - floor + delta - 1) / delta) * (factor + 1);
        do_reset();
        lv = 1'b1; val = 8'(v);
        @(posedge clk); #1;
        lv = 1'b0;
        n = 0;
        d = 1'b0;
        while (!d && n < 300) begin
            @(posedge clk); #1;
            n++;
            sample(sel, c, r, b, d);
        end
        chk("latency", v, n, exp_n);
    endtask

    initial begin
        vec_t       e;
        logic [7:0] c;
        logic       r, b, d;

        rst = 1'b1; ena = 1'b0; lv = 1'b0; val = '0; ar = 1'b0; ab = 1'b0;

        // Reset, including reset during a run
        add(0,1,0,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,0,0, 0,0,0);
        add(0,0,1,1,5,0,0, 5,1,0);
        add(0,0,1,0,0,0,0, 5,1,0);
        add(0,1,1,0,0,0,0, 0,0,0);
        add(0,1,1,0,0,0,0, 0,0,0);
        add(0,0,1,0,0,0,0, 0,0,0);
        // Defaults, load 3
        add(0,0,1,1,3,0,0, 3,1,0);
        add(0,0,1,0,0,0,0, 3,1,0);
        add(0,0,1,0,0,0,0, 2,1,0);
        add(0,0,1,0,0,0,0, 2,1,0);
        add(0,0,1,0,0,0,0, 1,1,0);
        add(0,0,1,0,0,0,0, 1,1,0);
        add(0,0,1,0,0,0,0, 0,0,1);
        add(0,0,1,0,0,0,0, 0,0,0);
        // Toggled enable, load 2, ignored loads while running
        add(0,0,1,1,2,0,0, 2,1,0);
        add(0,0,0,0,0,0,0, 2,1,0);
        add(0,0,1,1,9,0,0, 2,1,0);
        add(0,0,0,0,0,0,0, 2,1,0);
        add(0,0,1,0,0,0,0, 1,1,0);
        add(0,0,0,1,9,0,0, 1,1,0);
        add(0,0,1,0,0,0,0, 1,1,0);
        add(0,0,0,0,0,0,0, 1,1,0);
        add(0,0,1,0,0,0,0, 0,0,1);
        add(0,0,1,0,0,0,0, 0,0,0);
        // DELTA=3 FLOOR=2 FACTOR=0
        add(1,1,0,0,0,0,0, 0,0,0);
        add(1,0,1,1,10,0,0, 10,1,0);
        add(1,0,1,0,0,0,0, 7,1,0);
        add(1,0,1,0,0,0,0, 4,1,0);
        add(1,0,1,0,0,0,0, 2,0,1);
        add(1,0,1,0,0,0,0, 2,0,0);
        add(1,0,1,1,2,0,0, 2,0,1);
        add(1,0,1,0,0,0,0, 2,0,0);
        add(1,0,1,1,3,0,0, 3,1,0);
        add(1,0,1,0,0,0,0, 2,0,1);
        add(1,0,1,0,0,0,0, 2,0,0);
        // Auto-reload with FACTOR=0
        add(2,1,0,0,0,0,0, 0,0,0);
        add(2,0,1,1,2,1,0, 2,1,0);
        add(2,0,1,0,0,1,0, 1,1,0);
        add(2,0,1,0,0,1,0, 2,1,1);
        add(2,0,1,0,0,1,0, 1,1,0);
        add(2,0,1,0,0,1,0, 2,1,1);
        add(2,0,1,0,0,0,0, 1,1,0);
        add(2,0,1,0,0,0,0, 0,0,1);
        add(2,0,1,0,0,0,0, 0,0,0);
        // Abort on a step cycle, then a fresh load
        add(0,1,0,0,0,0,0, 0,0,0);
        add(0,0,1,1,5,0,0, 5,1,0);
        add(0,0,1,0,0,0,0, 5,1,0);
        add(0,0,1,0,0,0,0, 4,1,0);
        add(0,0,1,0,0,0,0, 4,1,0);
        add(0,0,1,0,0,0,0, 3,1,0);
        add(0,0,1,0,0,0,0, 3,1,0);
        add(0,0,1,0,0,0,1, 3,0,0);
        add(0,0,1,0,0,0,0, 3,0,0);
        add(0,0,1,0,0,0,1, 3,0,0);
        add(0,0,1,1,1,0,0, 1,1,0);
        add(0,0,1,0,0,0,0, 1,1,0);
        add(0,0,1,0,0,0,0, 0,0,1);
        add(0,0,1,0,0,0,0, 0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; ena = vecs[i].ena; lv = vecs[i].lv;
            val = vecs[i].val; ar = vecs[i].ar; ab = vecs[i].ab;
            sb.push_back(vecs[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            sample(e.sel, c, r, b, d);
            chk("count", i, c, e.cnt);
            chk("busy",  i, b, e.busy);
            chk("done",  i, d, e.done);
            chk("ready", i, r, !e.busy);
        end

        latency(0, 7, 1, 0, 1);
        latency(0, 1, 1, 0, 1);
        latency(1, 20, 3, 2, 0);
        latency(1, 19, 3, 2, 0);
        latency(2, 9, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
